// File: rtl/display_scheduler_if.sv
// Word handshake between the display scheduler, the SPI master and the config requester.
interface display_scheduler_if;
    logic        spi_ready;
    logic        spi_sent;
    logic        cs;
    logic [15:0] word;
    logic        cfg_req;
    logic [15:0] cfg_word;
    logic        cfg_ack;

    modport master (
        input  spi_ready, spi_sent, cfg_req, cfg_word,
        output cs, word, cfg_ack
    );

    modport slave (
        output spi_ready, spi_sent, cfg_req, cfg_word,
        input  cs, word, cfg_ack
    );
endinterface

// File: rtl/display_scheduler.sv
// Sequences MAX7219 words: power-up init list, 6-digit time frames on tick edges,
// and single external config words arbitrated between frames.
module display_scheduler #(
    parameter logic [7:0] SCAN_LIMIT = 8'd5,
    parameter logic [3:0] INTENSITY  = 4'd8
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       tick,
    input  logic                       ena,
    input  logic [3:0]                 ces_0X,
    input  logic [3:0]                 ces_X0,
    input  logic [3:0]                 sec_0X,
    input  logic [2:0]                 sec_X0,
    input  logic [3:0]                 min_0X,
    input  logic [2:0]                 min_X0,
    display_scheduler_if.master        bus,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);

    typedef enum logic [2:0] {
        StInitIssue,
        StInitWait,
        StIdle,
        StFrmIssue,
        StFrmWait,
        StCfgIssue,
        StCfgWait
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        cs_q, cs_d;
    logic [15:0] word_q, word_d;
    logic        cfg_ack_q, cfg_ack_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;
    logic        pending_q, pending_d;
    logic        tick_q;
    logic        rise_q;
    logic [21:0] snap_q, snap_d;
    logic        consume;
    logic [15:0] init_word;
    logic [15:0] frame_word;

    always_comb begin
        init_word = 16'h0000;
        case (idx_q)
            3'd0:    init_word = 16'h0C01;
            3'd1:    init_word = 16'h09FF;
            3'd2:    init_word = {8'h0B, SCAN_LIMIT};
            default: init_word = {8'h0A, 4'h0, INTENSITY};
        endcase
    end

    // Snapshot layout: min_X0[21:19] min_0X[18:15] sec_X0[14:12] sec_0X[11:8] ces_X0[7:4] ces_0X[3:0]
    always_comb begin
        frame_word = 16'h0000;
        case (idx_q)
            3'd0:    frame_word = {8'h01, 4'h0, snap_q[3:0]};
            3'd1:    frame_word = {8'h02, 4'h0, snap_q[7:4]};
            3'd2:    frame_word = {8'h03, 4'h8, snap_q[11:8]};
            3'd3:    frame_word = {8'h04, 5'h00, snap_q[14:12]};
            3'd4:    frame_word = {8'h05, 4'h8, snap_q[18:15]};
            3'd5:    frame_word = {8'h06, 5'h00, snap_q[21:19]};
            default: frame_word = 16'h0000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cs_d         = cs_q;
        word_d       = word_q;
        cfg_ack_d    = 1'b0;
        frame_done_d = 1'b0;
        snap_d       = snap_q;
        consume      = 1'b0;

        case (state_q)
            StInitIssue: begin
                if (bus.spi_ready) begin
                    word_d  = init_word;
                    cs_d    = 1'b0;
                    state_d = StInitWait;
                end
            end
            StInitWait: begin
                if (bus.spi_sent) begin
                    cs_d = 1'b1;
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StInitIssue;
                    end
                end
            end
            StIdle: begin
                if (bus.cfg_req) begin
                    state_d = StCfgIssue;
                end else if (pending_q) begin
                    consume = 1'b1;
                    snap_d  = {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};
                    idx_d   = 3'd0;
                    state_d = StFrmIssue;
                end
            end
            StFrmIssue: begin
                if (bus.spi_ready) begin
                    word_d  = frame_word;
                    cs_d    = 1'b0;
                    state_d = StFrmWait;
                end
            end
            StFrmWait: begin
                if (bus.spi_sent) begin
                    cs_d = 1'b1;
                    if (idx_q == 3'd5) begin
                        frame_done_d = 1'b1;
                        idx_d        = 3'd0;
                        state_d      = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StFrmIssue;
                    end
                end
            end
            StCfgIssue: begin
                if (bus.spi_ready) begin
                    word_d  = bus.cfg_word;
                    cs_d    = 1'b0;
                    state_d = StCfgWait;
                end
            end
            StCfgWait: begin
                if (bus.spi_sent) begin
                    cs_d      = 1'b1;
                    cfg_ack_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StInitIssue;
        endcase
    end

    // A new edge landing on the consuming cycle re-arms pending rather than overrunning.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (consume) begin
            pending_d = 1'b0;
        end
        if (rise_q) begin
            if (pending_q && !consume) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= StInitIssue;
            idx_q        <= 3'd0;
            cs_q         <= 1'b1;
            word_q       <= 16'h0000;
            cfg_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            pending_q    <= 1'b0;
            tick_q       <= 1'b0;
            rise_q       <= 1'b0;
            snap_q       <= 22'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cs_q         <= cs_d;
            word_q       <= word_d;
            cfg_ack_q    <= cfg_ack_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            pending_q    <= pending_d;
            tick_q       <= tick;
            rise_q       <= tick & ~tick_q & ena;
            snap_q       <= snap_d;
        end
    end

    assign bus.cs      = cs_q;
    assign bus.word    = word_q;
    assign bus.cfg_ack = cfg_ack_q;
    assign busy        = (state_q != StIdle);
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

endmodule
